// File: rtl/apb_gpio_debounce.sv
// -----------------------------------------------------------------------------
// apb_gpio_debounce
//
// APB3 GPIO peripheral for board LEDs and slide switches. Every input bit is
// synchronised and debounced before software can see it. Per-bit rising and
// falling edges of the debounced value feed a sticky write-1-to-clear status
// register, which drives a single level interrupt.
//
// Register map (byte offsets, bits at and above GPIO_WIDTH read 0):
//   0x00 DIN        RO   debounced inputs (writes ignored, no error)
//   0x04 DOUT       RW   drives gpio_out
//   0x08 RISE_EN    RW   rising-edge status enable
//   0x0C FALL_EN    RW   falling-edge status enable
//   0x10 IRQ_STATUS W1C  sticky edge status
//   Any other offset, an unaligned address or nonzero address bits above [4:0]
//   raise pslverror, read 0 and ignore the write.
//
// APB handshake: zero wait states. pready = psel & penable; a transfer
// completes in the access phase it is presented in. prdata and pslverror are
// combinational during the access phase and 0 otherwise. A write commits on
// the clk edge that ends the access phase.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   s_apb_*             APB3 slave port
//   gpio_in             asynchronous switch inputs
//   gpio_out            LED drive (DOUT)
//   irq                 OR of IRQ_STATUS
// -----------------------------------------------------------------------------
module apb_gpio_debounce #(
  parameter int ADDR_WIDTH      = 32,
  parameter int GPIO_WIDTH      = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter logic [GPIO_WIDTH-1:0] OUT_RESET = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_apb_paddr,
  input  logic                  s_apb_psel,
  input  logic                  s_apb_penable,
  input  logic                  s_apb_pwrite,
  input  logic [31:0]           s_apb_pwdata,
  output logic                  s_apb_pready,
  output logic [31:0]           s_apb_prdata,
  output logic                  s_apb_pslverror,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  irq
);

  // A counter of at least one bit keeps DEBOUNCE_CYCLES=1 legal; its only
  // value is then 0, so a difference is accepted on the first cycle.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Word index (paddr[4:2]) of each register
  localparam logic [2:0] REG_DIN  = 3'd0;
  localparam logic [2:0] REG_DOUT = 3'd1;
  localparam logic [2:0] REG_RISE = 3'd2;
  localparam logic [2:0] REG_FALL = 3'd3;
  localparam logic [2:0] REG_STAT = 3'd4;

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic                  w_access;
  logic                  w_upper_zero;
  logic                  w_addr_ok;
  logic                  w_wr;
  logic [2:0]            w_word;
  logic [GPIO_WIDTH-1:0] w_wdata;
  logic                  w_unused_pwdata;

  assign w_access     = s_apb_psel & s_apb_penable;
  assign w_upper_zero = ((s_apb_paddr >> 5) == '0);
  assign w_word       = s_apb_paddr[4:2];
  assign w_addr_ok    = w_upper_zero && (s_apb_paddr[1:0] == 2'b00) &&
                        (w_word <= REG_STAT);
  assign w_wr         = w_access & s_apb_pwrite & w_addr_ok;
  assign w_wdata      = s_apb_pwdata[GPIO_WIDTH-1:0];

  // pwdata bits above GPIO_WIDTH have no destination
  assign w_unused_pwdata = ^s_apb_pwdata;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [GPIO_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] w_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= gpio_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce: a bit's debounced value follows the synchronised value only after
  // the two have disagreed for DEBOUNCE_CYCLES consecutive cycles. Any
  // agreement restarts the count, so short pulses are dropped.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]      r_cnt [GPIO_WIDTH];
  logic [GPIO_WIDTH-1:0] r_din;
  logic [GPIO_WIDTH-1:0] w_upd;
  logic [GPIO_WIDTH-1:0] w_rise;
  logic [GPIO_WIDTH-1:0] w_fall;

  always_comb begin
    w_upd = '0;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      w_upd[i] = (w_sync[i] != r_din[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  // The debounced bit takes the synchronised value, so its direction tells
  // which kind of edge is happening on this clock.
  assign w_rise = w_upd & w_sync;
  assign w_fall = w_upd & ~w_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_din <= '0;
      for (int i = 0; i < GPIO_WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < GPIO_WIDTH; i++) begin
        if (w_sync[i] == r_din[i]) begin
          r_cnt[i] <= '0;
        end else if (w_upd[i]) begin
          r_din[i] <= w_sync[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Software registers
  // ---------------------------------------------------------------------------
  logic [GPIO_WIDTH-1:0] r_dout;
  logic [GPIO_WIDTH-1:0] r_rise_en;
  logic [GPIO_WIDTH-1:0] r_fall_en;
  logic [GPIO_WIDTH-1:0] r_stat;
  logic [GPIO_WIDTH-1:0] w_set;
  logic [GPIO_WIDTH-1:0] w_clr;

  // Enables are sampled before any write on the same edge takes effect, so an
  // enable change never acts retroactively on an edge.
  assign w_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_clr = (w_wr && (w_word == REG_STAT)) ? w_wdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout    <= OUT_RESET;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_stat    <= '0;
    end else begin
      if (w_wr && (w_word == REG_DOUT)) r_dout    <= w_wdata;
      if (w_wr && (w_word == REG_RISE)) r_rise_en <= w_wdata;
      if (w_wr && (w_word == REG_FALL)) r_fall_en <= w_wdata;
      // Set is OR-ed in after the clear so a simultaneous event survives W1C
      r_stat <= (r_stat & ~w_clr) | w_set;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and outputs
  // ---------------------------------------------------------------------------
  logic [GPIO_WIDTH-1:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    case (w_word)
      REG_DIN:  w_rdata = r_din;
      REG_DOUT: w_rdata = r_dout;
      REG_RISE: w_rdata = r_rise_en;
      REG_FALL: w_rdata = r_fall_en;
      REG_STAT: w_rdata = r_stat;
      default:  w_rdata = '0;
    endcase
  end

  assign s_apb_pready    = w_access;
  assign s_apb_prdata    = (w_access && w_addr_ok) ? 32'(w_rdata) : 32'd0;
  assign s_apb_pslverror = w_access & ~w_addr_ok;
  assign gpio_out        = r_dout;
  assign irq             = |r_stat;

endmodule
